// File: rtl/ultra_echo_ranger.sv
// Ultrasonic ranger: periodic trigger pulse, echo width measured in TICK_DIV-cycle units (cm).
// Latency: echo pin edge reaches the FSM 3 clk later; DONE/ABORT strobes are registered, one cycle each.
// Backpressure: none; a period start that arrives while busy is dropped, results are fire-and-forget strobes.
module ultra_echo_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TICK_DIV       = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int DIST_W         = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int CW = $clog2(TRIG_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);

  localparam logic [PW-1:0]     PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0]     TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [OW-1:0]     TMO_LAST  = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DIST_W-1:0] DIST_MAX  = {DIST_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_LOW, S_WAIT_RISE, S_MEASURE, S_DONE, S_ABORT
  } state_t;

  state_t            state_q;
  logic              echo_s1_q, echo_s2_q, echo_s3_q;
  logic [PW-1:0]     per_q, per_d;
  logic [CW-1:0]     cyc_q;
  logic [OW-1:0]     tmo_q;
  logic [TW-1:0]     tick_q, tick_d;
  logic [DIST_W-1:0] dcnt_q, dcnt_d;
  logic [DIST_W-1:0] dist_q;
  logic              trig_q, busy_q, valid_q, timeout_q;
  logic              start_req, tick_wrap, tmo_exp, echo_rise, echo_fall;

  // Two-flop synchronizer for the asynchronous echo pin, plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  // Next-state helpers: period wrap, tick wrap, saturating distance increment, edge and expiry flags.
  always_comb begin
    start_req = (per_q == PER_LAST);
    per_d     = start_req ? '0 : per_q + 1'b1;
    tick_wrap = (tick_q == TICK_LAST);
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    dcnt_d    = (tick_wrap && dcnt_q != DIST_MAX) ? dcnt_q + 1'b1 : dcnt_q;
    tmo_exp   = (tmo_q == TMO_LAST);
    echo_rise = echo_s2_q & ~echo_s3_q;
    echo_fall = ~echo_s2_q & echo_s3_q;
  end

  // Free-running period counter; its wrap cycle is the trigger start request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) per_q <= '0;
    else     per_q <= per_d;
  end

  // Measurement FSM with registered trig/busy/valid/timeout/dist outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      tmo_q     <= '0;
      tick_q    <= '0;
      dcnt_q    <= '0;
      dist_q    <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q <= S_TRIG;
            cyc_q   <= '0;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_TRIG: begin
          if (cyc_q == TRIG_LAST) begin
            state_q <= S_WAIT_LOW;
            trig_q  <= 1'b0;
            tmo_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_WAIT_LOW: begin
          if (tmo_exp) begin
            state_q   <= S_ABORT;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            // a still-high echo here is left over from an earlier shot
            if (!echo_s2_q) state_q <= S_WAIT_RISE;
          end
        end
        S_WAIT_RISE: begin
          if (tmo_exp) begin
            state_q   <= S_ABORT;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (echo_rise) begin
              state_q <= S_MEASURE;
              tick_q  <= '0;
              dcnt_q  <= '0;
            end
          end
        end
        S_MEASURE: begin
          // falling edge beats a simultaneous expiry; the fall cycle itself is counted
          if (echo_fall) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            dist_q  <= dcnt_d;
          end else if (tmo_exp) begin
            state_q   <= S_ABORT;
            timeout_q <= 1'b1;
          end else begin
            tmo_q  <= tmo_q + 1'b1;
            tick_q <= tick_d;
            dcnt_q <= dcnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_ABORT: begin
          state_q   <= S_IDLE;
          timeout_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trig    = trig_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign dist_cm = dist_q;

endmodule

// File: tb/tb_ultra_echo_ranger.sv
// Bench for ultra_echo_ranger with small timing parameters.
// Each period's echo is described as (stale pulse, delay, width) relative to trig fall.
// Expected outputs come from the timing rules: result at fall+2, timeout at trig fall+TMO.
module tb_ultra_echo_ranger;
  localparam int TRIG  = 4;
  localparam int TICKD = 10;
  localparam int TMO   = 200;
  localparam int PER   = 400;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          echo = 1'b0;
  logic          trig, valid, timeout, busy;
  logic [DW-1:0] dist_cm;

  int            vectors = 0;
  int            miscompares = 0;
  int            n = 0;               // clock edges since reset release
  logic [DW-1:0] dist_hold = '0;      // last published distance

  // current period's echo description
  int sc_k, sc_s, sc_d, sc_w;
  bit sc_has, sc_stale;

  ultra_echo_ranger #(
    .TRIG_CYCLES(TRIG), .TICK_DIV(TICKD), .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES(PER), .DIST_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .dist_cm(dist_cm),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW+3:0] expv);
    logic [DW+3:0] obs;
    obs = {trig, busy, valid, timeout, dist_cm};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed{trig,busy,valid,timeout,dist}=%b expected=%b", tag, n, obs, expv);
    end
  endtask

  // Echo pin level sampled at clock edge e.
  function automatic logic echo_at(input int e);
    int rel;
    rel = e - (PER * sc_k + TRIG);
    return (sc_stale && rel >= -3 && rel < sc_s) || (sc_has && rel >= sc_d && rel < sc_d + sc_w);
  endfunction

  // No trigger expected: outputs idle, distance held.
  task automatic run_idle(input string tag, input int last);
    for (int e = n + 1; e <= last; e++) begin
      echo = 1'b0;
      @(posedge clk);
      n = e;
      #1;
      check(tag, {4'b0000, dist_hold});
    end
  endtask

  // Period k: trigger at edge PER*k, echo as described, run up to edge 'last'.
  task automatic run_period(input string tag, input int k, input bit has, input bit stale,
                            input int s, input int d, input int w, input int last);
    int t_fall, end_e, dnew;
    bit ok, et, eb, ev, eo;
    sc_k = k; sc_has = has; sc_stale = stale; sc_s = s; sc_d = d; sc_w = w;
    t_fall = PER * k + TRIG;
    ok     = has && (d + w + 2 <= TMO);
    end_e  = ok ? t_fall + d + w + 2 : t_fall + TMO;
    dnew   = w / TICKD;
    if (dnew > (1 << DW) - 1) dnew = (1 << DW) - 1;
    for (int e = n + 1; e <= last; e++) begin
      echo = echo_at(e);
      @(posedge clk);
      n = e;
      #1;
      if (ok && e == end_e) dist_hold = DW'(dnew);
      et = (e >= PER * k) && (e < t_fall);
      eb = (e >= PER * k) && (e <= end_e);
      ev = ok && (e == end_e);
      eo = !ok && (e == end_e);
      check(tag, {et, eb, ev, eo, dist_hold});
    end
  endtask

  initial begin
    bit has, stale;
    int s, d, w;

    #1 rst = 1'b1;
    #1 check("reset_async", '0);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", '0);
    rst = 1'b0;
    n = 0;

    run_idle("first_period_idle", PER - 1);
    run_period("no_echo_timeout", 1, 0, 0, 0, 0, 0, 2 * PER - 1);
    run_period("echo57_dist5", 2, 1, 0, 0, 20, 57, 3 * PER - 1);
    run_period("echo180_saturate", 3, 1, 0, 0, 5, 180, 4 * PER - 1);
    run_period("stale_then_30", 4, 1, 1, 6, 15, 30, 5 * PER - 1);
    run_period("fall_on_expiry", 5, 1, 0, 0, 98, 100, 6 * PER - 1);
    run_period("fall_after_expiry", 6, 1, 0, 0, 99, 100, 7 * PER - 1);

    // reset while measuring: everything clears without a clock edge
    run_period("pre_reset_measure", 7, 1, 0, 0, 20, 57, 7 * PER + TRIG + 30);
    #2 rst = 1'b1;
    #1 check("reset_in_measure", '0);
    @(posedge clk);
    #1 check("reset_in_measure_hold", '0);
    rst = 1'b0;
    n = 0;
    dist_hold = '0;
    echo = 1'b0;

    run_idle("idle_after_reset1", PER - 1);
    run_period("trig_after_reset1", 1, 0, 0, 0, 0, 0, PER + 1);

    // reset while trig is high
    #2 rst = 1'b1;
    #1 check("reset_in_trig", '0);
    @(posedge clk);
    #1 check("reset_in_trig_hold", '0);
    rst = 1'b0;
    n = 0;

    run_idle("idle_after_reset2", PER - 1);
    for (int k = 1; k <= 6; k++) begin
      has   = ($urandom_range(0, 4) != 0);
      stale = ($urandom_range(0, 1) != 0);
      s     = $urandom_range(1, 10);
      d     = stale ? $urandom_range(s + 2, 120) : $urandom_range(1, 120);
      w     = $urandom_range(1, 190);
      run_period("random_period", k, has, stale, s, d, w, PER * (k + 1) - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
